// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select encodings, divide states and register-match helper
package hazard_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divState_t;
  function automatic logic regHit(input logic [4:0] src, input logic [4:0] dst, input logic en);
    return en & (src != 5'd0) & (src == dst);
  endfunction
endpackage

// File: rtl/hazard_unit_div_seq.sv
// div_seq: multi-cycle divide sequencer that holds F/D/E while the divider runs
module div_seq
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic divstartE,
  output logic divstall,
  output logic divbusy,
  output logic divdoneE
);
  divState_t state;
  logic [CNT_W-1:0] cnt;
  // IDLE -> BUSY on a new div, count down, then one DONE cycle for the HI/LO write
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: if (divstartE) begin
          state <= DIV_BUSY;
          cnt <= CNT_W'(DIV_CYCLES - 2);
        end
        DIV_BUSY: if (cnt == '0) state <= DIV_DONE; else cnt <= cnt - 1'b1;
        DIV_DONE: state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end
  assign divstall = (state == DIV_IDLE & divstartE) | (state == DIV_BUSY);
  assign divbusy = state != DIV_IDLE;
  assign divdoneE = state == DIV_DONE;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage pipeline
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic       jrD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic       divstartE,
  input  logic [4:0] writeregM,
  input  logic       regwriteM,
  input  logic       memtoregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteW,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       flushM,
  output logic       forwardaD,
  output logic       forwardbD,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE,
  output logic       divbusy,
  output logic       divdoneE
);
  logic divstall, lwstall, branchstall, hzstall, rsHitE, rtHitE, rsHitM, rtHitM;
  div_seq #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_div (
    .clk(clk), .rst(rst), .divstartE(divstartE),
    .divstall(divstall), .divbusy(divbusy), .divdoneE(divdoneE)
  );
  // forwarding selects (M beats W) and decode-stage hazard detection
  always_comb begin
    forwardaE = regHit(rsE, writeregM, regwriteM) ? FWD_MEM : regHit(rsE, writeregW, regwriteW) ? FWD_WB : FWD_REG;
    forwardbE = regHit(rtE, writeregM, regwriteM) ? FWD_MEM : regHit(rtE, writeregW, regwriteW) ? FWD_WB : FWD_REG;
    forwardaD = regHit(rsD, writeregM, regwriteM);
    forwardbD = regHit(rtD, writeregM, regwriteM);
    lwstall = regHit(rsD, writeregE, memtoregE) | regHit(rtD, writeregE, memtoregE);
    rsHitE = regHit(rsD, writeregE, regwriteE);
    rtHitE = regHit(rtD, writeregE, regwriteE);
    rsHitM = regHit(rsD, writeregM, memtoregM);
    rtHitM = regHit(rtD, writeregM, memtoregM);
    branchstall = (branchD & (rsHitE | rtHitE | rsHitM | rtHitM)) | (jrD & (rsHitE | rsHitM));
    hzstall = lwstall | branchstall;
    stallF = divstall | hzstall;
    stallD = divstall | hzstall;
    stallE = divstall;
    flushM = divstall;
    flushE = hzstall & ~divstall;
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a behavioural model
module tb_hazard_unit;
  localparam int DC = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, jrD, regwriteE, memtoregE, divstartE, regwriteM, memtoregM, regwriteW;
  logic stallF, stallD, stallE, flushE, flushM, forwardaD, forwardbD, divbusy, divdoneE;
  logic [1:0] forwardaE, forwardbE;
  int vectors = 0;
  int miscompares = 0;
  int occ = 0;
  bit checkEn = 1'b0;

  hazard_unit #(.DIV_CYCLES(DC), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .divstartE(divstartE), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .writeregW(writeregW),
    .regwriteW(regwriteW), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM), .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .divbusy(divbusy), .divdoneE(divdoneE)
  );

  function automatic bit hit(input logic [4:0] s, input logic [4:0] d, input logic en);
    return en && s != 0 && s == d;
  endfunction

  task automatic chk(input string n, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, act, exp);
    end
  endtask

  // occ = how many cycles the current divide has already spent in E (0 = none)
  always @(posedge clk)
    occ <= rst ? 0 : occ == 0 ? (divstartE ? 1 : 0) : occ == DC ? 0 : occ + 1;

  always @(negedge clk) if (checkEn) begin
    bit lw, br, hz, ds;
    logic [1:0] fa, fb;
    lw = memtoregE && (rsD != 0 && rsD == writeregE || rtD != 0 && rtD == writeregE);
    br = branchD && (hit(rsD, writeregE, regwriteE) || hit(rtD, writeregE, regwriteE) ||
                     hit(rsD, writeregM, memtoregM) || hit(rtD, writeregM, memtoregM)) ||
         jrD && (hit(rsD, writeregE, regwriteE) || hit(rsD, writeregM, memtoregM));
    hz = lw || br;
    ds = occ == 0 ? divstartE : occ < DC;
    fa = hit(rsE, writeregM, regwriteM) ? 2'd2 : hit(rsE, writeregW, regwriteW) ? 2'd1 : 2'd0;
    fb = hit(rtE, writeregM, regwriteM) ? 2'd2 : hit(rtE, writeregW, regwriteW) ? 2'd1 : 2'd0;
    chk("m_stallF", {1'b0, stallF}, {1'b0, ds | hz});
    chk("m_stallD", {1'b0, stallD}, {1'b0, ds | hz});
    chk("m_stallE", {1'b0, stallE}, {1'b0, ds});
    chk("m_flushM", {1'b0, flushM}, {1'b0, ds});
    chk("m_flushE", {1'b0, flushE}, {1'b0, hz & !ds});
    chk("m_fwdaD", {1'b0, forwardaD}, {1'b0, hit(rsD, writeregM, regwriteM)});
    chk("m_fwdbD", {1'b0, forwardbD}, {1'b0, hit(rtD, writeregM, regwriteM)});
    chk("m_fwdaE", forwardaE, fa);
    chk("m_fwdbE", forwardbE, fb);
    chk("m_divbusy", {1'b0, divbusy}, {1'b0, occ != 0});
    chk("m_divdone", {1'b0, divdoneE}, {1'b0, occ == DC});
  end

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {branchD, jrD, regwriteE, memtoregE, divstartE, regwriteM, memtoregM, regwriteW} = '0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    cyc();
    checkEn = 1'b1;
    look();
    chk("rst_stallF", {1'b0, stallF}, 2'd0);
    chk("rst_divbusy", {1'b0, divbusy}, 2'd0);
    chk("rst_fwdaE", forwardaE, 2'd0);
    chk("rst_flushE", {1'b0, flushE}, 2'd0);
    cyc();
    rst = 1'b0;
    rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
    look(); chk("fwd_mem", forwardaE, 2'b10);
    cyc(); regwriteM = 0;
    look(); chk("fwd_wb", forwardaE, 2'b01);
    cyc(); rsE = 0;
    look(); chk("fwd_r0", forwardaE, 2'b00);
    cyc(); clr(); memtoregE = 1; writeregE = 8; rtD = 8;
    look();
    chk("lw_stallF", {1'b0, stallF}, 2'd1);
    chk("lw_stallD", {1'b0, stallD}, 2'd1);
    chk("lw_flushE", {1'b0, flushE}, 2'd1);
    cyc(); clr(); rtD = 8; writeregM = 8; regwriteM = 1; memtoregM = 1;
    look();
    chk("lw_done_stall", {1'b0, stallF}, 2'd0);
    chk("lw_done_flush", {1'b0, flushE}, 2'd0);
    cyc(); clr(); branchD = 1; rsD = 9; regwriteE = 1; writeregE = 9;
    look();
    chk("br_stall", {1'b0, stallF}, 2'd1);
    chk("br_flushE", {1'b0, flushE}, 2'd1);
    cyc(); regwriteE = 0; writeregE = 0; writeregM = 9; regwriteM = 1;
    look();
    chk("br_m_stall", {1'b0, stallF}, 2'd0);
    chk("br_fwdaD", {1'b0, forwardaD}, 2'd1);
    cyc(); clr(); jrD = 1; rtD = 9; regwriteE = 1; writeregE = 9;
    look(); chk("jr_rt_only", {1'b0, stallF}, 2'd0);
    cyc(); clr(); divstartE = 1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) divstartE = 0;
      look();
      chk("div_stallE", {1'b0, stallE}, {1'b0, k <= 4});
      chk("div_flushM", {1'b0, flushM}, {1'b0, k <= 4});
      chk("div_stallF", {1'b0, stallF}, {1'b0, k <= 4});
      chk("div_flushE", {1'b0, flushE}, 2'd0);
      chk("div_done", {1'b0, divdoneE}, {1'b0, k == 5});
      chk("div_busy", {1'b0, divbusy}, {1'b0, k >= 2 && k <= 5});
      cyc();
    end
    divstartE = 1;
    for (int k = 1; k <= 10; k++) begin
      look();
      chk("b2b_stallE", {1'b0, stallE}, {1'b0, k % 5 != 0});
      chk("b2b_done", {1'b0, divdoneE}, {1'b0, k % 5 == 0});
      cyc();
    end
    divstartE = 0;
    cyc(); divstartE = 1;
    cyc();
    cyc(); rst = 1;
    look(); chk("abort_busy_pre", {1'b0, divbusy}, 2'd1);
    cyc(); rst = 0; divstartE = 0;
    for (int k = 0; k < 2; k++) begin
      look();
      chk("abort_busy", {1'b0, divbusy}, 2'd0);
      chk("abort_done", {1'b0, divdoneE}, 2'd0);
      chk("abort_stallF", {1'b0, stallF}, 2'd0);
      cyc();
    end
    clr(); divstartE = 1; memtoregE = 1; writeregE = 8; rtD = 8;
    for (int k = 1; k <= 5; k++) begin
      look();
      chk("ovl_flushE", {1'b0, flushE}, {1'b0, k == 5});
      chk("ovl_stallE", {1'b0, stallE}, {1'b0, k <= 4});
      chk("ovl_stallF", {1'b0, stallF}, 2'd1);
      cyc();
    end
    clr();
    look(); chk("ovl_resolved", {1'b0, stallF}, 2'd0);
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = $urandom_range(0, 199) == 0;
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      {branchD, jrD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW} = 7'($urandom);
      divstartE = occ != 0 && occ < DC ? 1'b1 : $urandom_range(0, 5) == 0;
    end
    cyc();
    rst = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
